// File: rtl/log_lane_scheduler_if.sv
// Control and status bundle between the game FSM and the log lane scheduler.
// The master side drives run/pause/stop and level offers; the slave side returns lane step pulses and status.
interface log_lane_scheduler_if #(
  parameter int NUM_LANES = 6
);
  logic                 start;
  logic                 pause;
  logic                 stop;
  logic                 level_valid;
  logic [2:0]           level;
  logic                 level_ready;
  logic [NUM_LANES-1:0] step;
  logic [NUM_LANES-1:0] dir;
  logic                 running;
  logic                 busy;
  logic [2:0]           cur_level;

  modport master (
    output start, pause, stop, level_valid, level,
    input  level_ready, step, dir, running, busy, cur_level
  );

  modport slave (
    input  start, pause, stop, level_valid, level,
    output level_ready, step, dir, running, busy, cur_level
  );
endinterface

// File: rtl/log_lane_scheduler.sv
// Per-lane speed dividers for the river logs, emitting one-cycle step pulses.
// A level change rewrites the dividers one lane per cycle, then resumes the previous mode.
module log_lane_scheduler #(
  parameter int                   NUM_LANES     = 6,
  parameter int                   CNT_W         = 24,
  parameter int                   BASE_DIV_EVEN = 150000,
  parameter int                   BASE_DIV_ODD  = 200000,
  parameter int                   DEC_STEP      = 15000,
  parameter int                   MIN_DIV       = 20000,
  parameter logic [NUM_LANES-1:0] DIR_MASK      = 6'b101010
) (
  input  logic                  clk,
  input  logic                  rst_n,
  log_lane_scheduler_if.slave   bus
);

  localparam int K_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int WW  = CNT_W + 4;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LOAD} state_e;

  state_e                   state_q, state_d;
  state_e                   ret_q, ret_d;
  logic [2:0]               pend_q, pend_d;
  logic [2:0]               cur_level_q, cur_level_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [CNT_W-1:0]         cnt_q [NUM_LANES];
  logic [CNT_W-1:0]         cnt_d [NUM_LANES];
  logic [CNT_W-1:0]         div_q [NUM_LANES];
  logic [CNT_W-1:0]         div_d [NUM_LANES];
  logic [NUM_LANES-1:0]     step_q, step_d;
  logic                     running_q, running_d;
  logic                     busy_q, busy_d;
  logic                     ready_q, ready_d;

  logic [WW-1:0]            base_w;
  logic [WW-1:0]            dec_w;
  logic [WW-1:0]            diff_w;
  logic [CNT_W-1:0]         load_div;

  function automatic logic [CNT_W-1:0] base_div(input logic [K_W-1:0] lane);
    return lane[0] ? CNT_W'(BASE_DIV_ODD) : CNT_W'(BASE_DIV_EVEN);
  endfunction

  // Divider for the lane being loaded, clamped to the floor on underflow or when too fast.
  always_comb begin
    base_w = WW'(base_div(k_q));
    dec_w  = WW'(pend_q) * WW'(DEC_STEP);
    diff_w = base_w - dec_w;
    if ((dec_w > base_w) || (diff_w < WW'(MIN_DIV))) begin
      load_div = CNT_W'(MIN_DIV);
    end else begin
      load_div = diff_w[CNT_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    pend_d      = pend_q;
    cur_level_d = cur_level_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    step_d      = '0;

    if (state_q == LOAD) begin
      div_d[k_q] = load_div;
      if (k_q == K_W'(NUM_LANES - 1)) begin
        cur_level_d = pend_q;
        for (int i = 0; i < NUM_LANES; i++) cnt_d[i] = '0;
        k_d     = '0;
        state_d = ret_q;
      end else begin
        k_d = k_q + 1'b1;
      end
    end else if (bus.stop) begin
      state_d = IDLE;
      for (int i = 0; i < NUM_LANES; i++) cnt_d[i] = '0;
    end else if (bus.level_valid) begin
      pend_d  = bus.level;
      ret_d   = state_q;
      k_d     = '0;
      state_d = LOAD;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) state_d = RUN;
        end
        RUN: begin
          // Pause freezes the counters on the very edge it is seen.
          if (bus.pause) begin
            state_d = PAUSE;
          end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
              if (cnt_q[i] >= div_q[i]) begin
                cnt_d[i]  = '0;
                step_d[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (!bus.pause) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
    busy_d    = (state_d == LOAD);
    ready_d   = (state_d != LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      pend_q      <= '0;
      cur_level_q <= '0;
      k_q         <= '0;
      step_q      <= '0;
      running_q   <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= base_div(K_W'(i));
      end
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      pend_q      <= pend_d;
      cur_level_q <= cur_level_d;
      k_q         <= k_d;
      step_q      <= step_d;
      running_q   <= running_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
    end
  end

  assign bus.step        = step_q;
  assign bus.dir         = DIR_MASK;
  assign bus.running     = running_q;
  assign bus.busy        = busy_q;
  assign bus.level_ready = ready_q;
  assign bus.cur_level   = cur_level_q;

endmodule
